// File: rtl/i2c_slave.sv
// i2c_slave: single-address I2C target bridging open-drain SCL/SDA pads to a parallel byte interface.
// Latency: pad edge to internal strobe 3 clk_i (+2 with I2C_SLAVE_GLITCH_FILTER_EN); sda_oe_o moves 1 clk_i after scl_fall.
// Backpressure: none; the bus master paces transfers, data_i must be valid by the SCL fall following rd_req_o.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample persistence filter behind each synchroniser.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       wr_valid_o,
    output logic       rd_req_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_c;
    logic       sda_c;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Two-flop synchronisers. Deliberately unreset: they always track the pads,
    // so a reset in the middle of a transfer can never fabricate a START edge.
    always_ff @(posedge clk_i) begin
        scl_sync_q <= {scl_sync_q[0], scl_i};
        sda_sync_q <= {sda_sync_q[0], sda_i};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_flt_q;
    logic       sda_flt_q;
    logic       scl_flt_d;
    logic       sda_flt_d;

    // Accept a new level only when the current and two previous samples agree.
    always_comb begin
        scl_flt_d = scl_flt_q;
        sda_flt_d = sda_flt_q;
        if (scl_hist_q == {2{scl_sync_q[1]}}) begin
            scl_flt_d = scl_sync_q[1];
        end
        if (sda_hist_q == {2{sda_sync_q[1]}}) begin
            sda_flt_d = sda_sync_q[1];
        end
    end

    // Sample history and held filter level (unreset for the same reason as the synchronisers).
    always_ff @(posedge clk_i) begin
        scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
        scl_flt_q  <= scl_flt_d;
        sda_flt_q  <= sda_flt_d;
    end

    assign scl_c = scl_flt_d;
    assign sda_c = sda_flt_d;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    // Previous conditioned levels for edge and bus-condition detection.
    always_ff @(posedge clk_i) begin
        scl_prev_q <= scl_c;
        sda_prev_q <= sda_c;
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    // SDA moving while SCL is steadily high is a bus condition, never data.
    assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] cnt_q;
    logic       done_q;     // terminal flag: 8 bits taken (or read ACK sampled)
    logic       rw_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic       wr_valid_q;
    logic       rd_req_q;
    logic [7:0] data_q;

    // Single FSM with registered outputs; START/STOP override any SCL edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            if (start_det) begin
                state_q  <= S_ADDR;
                cnt_q    <= 3'd0;
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                cnt_q    <= 3'd0;
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end
                    S_ADDR: begin
                        if (scl_rise && !done_q) begin
                            shift_q <= {shift_q[6:0], sda_c};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                done_q <= 1'b1;
                            end
                        end else if (scl_fall && done_q) begin
                            cnt_q  <= 3'd0;
                            done_q <= 1'b0;
                            rw_q   <= shift_q[0];
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rd_req_q <= shift_q[0];
                                state_q  <= S_ADDR_ACK;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt_q <= 3'd0;
                            if (rw_q) begin
                                shift_q  <= data_i;
                                sda_oe_q <= ~data_i[7];
                                state_q  <= S_RD_DATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (scl_rise && !done_q) begin
                            shift_q <= {shift_q[6:0], sda_c};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                done_q     <= 1'b1;
                                data_q     <= {shift_q[6:0], sda_c};
                                wr_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && done_q) begin
                            cnt_q    <= 3'd0;
                            done_q   <= 1'b0;
                            sda_oe_q <= 1'b1;
                            state_q  <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        // The MSB went out on entry; each fall launches the next bit,
                        // the eighth fall ends the byte and hands SDA to the master.
                        if (scl_fall) begin
                            if (cnt_q == 3'd7) begin
                                cnt_q    <= 3'd0;
                                done_q   <= 1'b0;
                                sda_oe_q <= 1'b0;
                                rd_req_q <= 1'b1;
                                state_q  <= S_RD_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                                cnt_q    <= cnt_q + 3'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise && !done_q) begin
                            if (sda_c) begin
                                state_q <= S_IGNORE;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else if (scl_fall && done_q) begin
                            done_q   <= 1'b0;
                            shift_q  <= data_i;
                            sda_oe_q <= ~data_i[7];
                            state_q  <= S_RD_DATA;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign data_o     = data_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_req_o   = rd_req_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave over a wired-AND SDA model.
// Expected acks, bytes and pulse counts come from protocol-level rules applied to each transfer.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int         Q    = 10;      // quarter SCL period in clk cycles
    localparam logic [6:0] ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wr_valid;
    logic       rd_req;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         oe_cnt = 0;
    logic [7:0] wr_q[$];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe_o  (sda_oe),
        .data_i    (data_in),
        .data_o    (data_out),
        .wr_valid_o(wr_valid),
        .rd_req_o  (rd_req),
        .busy_o    (busy)
    );

    // Observe user-side pulses and SDA drive away from the active edge.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            wr_q.push_back(data_out);
        end
        if (rd_req) rd_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_cnt = 0;
        rd_cnt = 0;
        oe_cnt = 0;
        wr_q.delete();
    endtask

    task automatic start_cond();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; tick(Q);
        scl_m = 1'b1;
        if (glitch) begin
            tick(6);
            scl_m = 1'b0; tick(2);
            scl_m = 1'b1; tick(2 * Q - 8);
        end else begin
            tick(2 * Q);
        end
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
        recv_bit(x);
        ack = ~x;
    endtask

    // Reads one byte; the next byte to return is presented before the master's ACK bit.
    task automatic recv_byte(output logic [7:0] v, input logic last, input logic [7:0] nxt);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(x);
            v[i] = x;
        end
        data_in = nxt;
        send_bit(last, 1'b0);
    endtask

    // Generic transfer: the target acks only its own address; writes deliver every
    // byte once; reads request data once on the address ACK and once after every
    // byte shifted out (the master's ACK/NACK is not yet known at that point).
    task automatic do_xfer(input string tag, input logic [6:0] a, input logic rw,
                           input int n, input logic [31:0] pl);
        logic       ack;
        logic       match;
        logic [7:0] got;
        logic [7:0] nxt;
        int         exp_wr;
        int         exp_rd;
        match  = (a == ADDR);
        exp_wr = (match && !rw) ? n : 0;
        exp_rd = (match && rw) ? n + 1 : 0;
        clear_mon();
        if (rw) data_in = pl[7:0];
        start_cond();
        send_byte({a, rw}, -1, ack);
        checks++;
        if (ack !== match) begin
            errors++;
            $display("FAIL %s addr_ack: got %0b want %0b", tag, ack, match);
        end
        checks++;
        if (busy !== match) begin
            errors++;
            $display("FAIL %s busy_in_xfer: got %0b want %0b", tag, busy, match);
        end
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                send_byte(pl[8*i +: 8], -1, ack);
                checks++;
                if (ack !== match) begin
                    errors++;
                    $display("FAIL %s data_ack[%0d]: got %0b want %0b", tag, i, ack, match);
                end
            end
        end else if (match) begin
            for (int i = 0; i < n; i++) begin
                nxt = (i + 1 < n) ? pl[8*(i+1) +: 8] : 8'h00;
                recv_byte(got, i == n - 1, nxt);
                checks++;
                if (got !== pl[8*i +: 8]) begin
                    errors++;
                    $display("FAIL %s rd_byte[%0d]: got %02h want %02h", tag, i, got, pl[8*i +: 8]);
                end
            end
        end
        stop_cond();
        tick(4);
        checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s after_stop: busy %0b sda_oe %0b want 0 0", tag, busy, sda_oe);
        end
        checks++;
        if (wr_cnt != exp_wr) begin
            errors++;
            $display("FAIL %s wr_valid_count: got %0d want %0d", tag, wr_cnt, exp_wr);
        end
        checks++;
        if (rd_cnt != exp_rd) begin
            errors++;
            $display("FAIL %s rd_req_count: got %0d want %0d", tag, rd_cnt, exp_rd);
        end
        if (!match) begin
            checks++;
            if (oe_cnt != 0) begin
                errors++;
                $display("FAIL %s sda_oe_seen: got %0d cycles want 0", tag, oe_cnt);
            end
        end else if (!rw) begin
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== pl[8*i +: 8]) begin
                    errors++;
                    $display("FAIL %s wr_byte[%0d]: got %02h want %02h", tag, i, wr_q[i], pl[8*i +: 8]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        checks++;
        if ({sda_oe, data_out, wr_valid, rd_req, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got oe%0b data%02h wv%0b rq%0b busy%0b want all 0",
                     sda_oe, data_out, wr_valid, rd_req, busy);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_write();
        do_xfer("write", 7'h42, 1'b0, 1, 32'h0000_00A5);
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL write data_o: got %02h want a5", data_out);
        end
    endtask

    task automatic test_mismatch();
        do_xfer("mismatch", 7'h43, 1'b0, 1, 32'h0000_00FF);
    endtask

    task automatic test_read();
        do_xfer("read", 7'h42, 1'b1, 2, 32'h0000_C33C);
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] junk;
        junk = 8'($urandom);
        clear_mon();
        start_cond();
        send_byte(8'h84, -1, ack);
        for (int i = 7; i >= 4; i--) send_bit(junk[i], 1'b0);
        start_cond();
        send_byte(8'h84, -1, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rstart addr_ack: got %0b want 1", ack);
        end
        send_byte(8'h11, -1, ack);
        stop_cond();
        tick(4);
        checks++;
        if (wr_cnt != 1 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL rstart result: wr_valid %0d data_o %02h want 1 11", wr_cnt, data_out);
        end
    endtask

    task automatic test_reset_mid_read();
        logic       ack;
        logic       x;
        logic [7:0] d;
        d       = 8'($urandom) & 8'h7F;   // MSB 0 so the target is pulling SDA low
        data_in = d;
        start_cond();
        send_byte(8'h85, -1, ack);
        checks++;
        if (sda_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: sda_oe %0b busy %0b want 1 1", sda_oe, busy);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid post: sda_oe %0b busy %0b want 0 0", sda_oe, busy);
        end
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 7; i++) recv_bit(x);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) recv_bit(x);
        send_bit(1'b1, 1'b0);
        stop_cond();
        tick(4);
        checks++;
        if (oe_cnt != 0 || rd_cnt != 0 || wr_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid ignored: oe %0d rd %0d wr %0d busy %0b want 0 0 0 0",
                     oe_cnt, rd_cnt, wr_cnt, busy);
        end
        do_xfer("rst_mid_recover", ADDR, 1'b0, 1, $urandom);
    endtask

    task automatic test_glitch();
        logic       ack;
        logic [7:0] v;
        logic [7:0] exp_d;
        logic       exp_ack;
        v = 8'($urandom);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_d   = v;
        exp_ack = 1'b1;
`else
        // The extra clock re-samples bit 3 and the ACK lands one bit early.
        exp_d   = {v[7:3], v[3:1]};
        exp_ack = 1'b0;
`endif
        clear_mon();
        start_cond();
        send_byte(8'h84, -1, ack);
        send_byte(v, 3, ack);
        stop_cond();
        tick(4);
        checks++;
        if (data_out !== exp_d || wr_cnt != 1) begin
            errors++;
            $display("FAIL glitch data: got %02h (%0d pulses) want %02h (1)", data_out, wr_cnt, exp_d);
        end
        checks++;
        if (ack !== exp_ack) begin
            errors++;
            $display("FAIL glitch ack: got %0b want %0b", ack, exp_ack);
        end
    endtask

    task automatic test_random();
        logic [6:0]  a;
        logic        rw;
        int          n;
        logic [31:0] pl;
        for (int k = 0; k < 8; k++) begin
            a  = ($urandom_range(0, 1) == 0) ? ADDR : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            pl = $urandom;
            do_xfer("random", a, rw, n, pl);
        end
    endtask

    initial begin
        rst     = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        data_in = 8'h00;
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_reset_mid_read();
        test_glitch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
